// File: rtl/lvtram_pkg.sv
// Shared types and helpers for the live-value-table RAM.
package lvtram_pkg;

  typedef enum logic {INIT, RUN} state_t;

  // Width of an LVT entry; a single write port still needs one bit.
  function automatic int selwd(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lvtram_bank.sv
// One write port, rports combinational read ports; storage is not reset.
module lvtram_bank #(
  parameter int width  = 64,
  parameter int depth  = 64,
  parameter int rports = 2
) (
  input  logic                                   clk,
  input  logic                                   we,
  input  logic [$clog2(depth)-1:0]               wa,
  input  logic [width-1:0]                       wd,
  input  logic [rports-1:0][$clog2(depth)-1:0]   ra,
  output logic [rports-1:0][width-1:0]           rd
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_comb begin
    for (int r = 0; r < rports; r++) rd[r] = mem[ra[r]];
  end

endmodule

// File: rtl/lvtram.sv
// Multi-port RAM: per-write-port banks selected by a live-value table, registered reads.
// Define LVTRAM_BYPASS_EN to forward same-cycle write data to colliding reads.
//
// state | meaning
// INIT  | sweep zeroes bank 0 and the LVT, one entry per cycle; user access ignored
// RUN   | normal read/write operation, ready high
module lvtram
  import lvtram_pkg::*;
#(
  parameter int width  = 64,
  parameter int depth  = 64,
  parameter int rports = 2,
  parameter int wports = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear,
  output logic                                 ready,
  input  logic [rports-1:0]                    rena,
  input  logic [rports-1:0][$clog2(depth)-1:0] raddr,
  output logic [rports-1:0][width-1:0]         rvalue,
  input  logic [wports-1:0]                    wena,
  input  logic [wports-1:0][$clog2(depth)-1:0] waddr,
  input  logic [wports-1:0][width-1:0]         wvalue
);

  localparam int aw = $clog2(depth);
  localparam int sw = selwd(wports);

  state_t           state, state_nxt;
  logic [aw-1:0]    cnt, cnt_nxt;
  logic             run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      INIT: begin
        cnt_nxt = clear ? '0 : cnt + 1'b1;
        if (!clear && cnt == aw'(depth - 1)) state_nxt = RUN;
      end
      RUN: if (clear) state_nxt = INIT;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    ready = (state == RUN);
    run   = (state == RUN);
  end

  logic [wports-1:0]                          bwe;
  logic [wports-1:0][aw-1:0]                  bwa;
  logic [wports-1:0][width-1:0]               bwd;
  logic [wports-1:0][rports-1:0][width-1:0]   brd;

  // The sweep borrows bank 0's write port; user writes are dropped outside RUN.
  always_comb begin
    bwe = wena & {wports{run}};
    bwa = waddr;
    bwd = wvalue;
    if (!run) begin
      bwe[0] = 1'b1;
      bwa[0] = cnt;
      bwd[0] = '0;
    end
  end

  for (genvar g = 0; g < wports; g++) begin : g_bank
    lvtram_bank #(.width(width), .depth(depth), .rports(rports)) u_bank (
      .clk (clk),
      .we  (bwe[g]),
      .wa  (bwa[g]),
      .wd  (bwd[g]),
      .ra  (raddr),
      .rd  (brd[g])
    );
  end

  logic [sw-1:0] lvt [depth];

  // Ascending loop: the highest-index port wins a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < depth; a++) lvt[a] <= '0;
    end else if (!run) begin
      lvt[cnt] <= '0;
    end else begin
      for (int i = 0; i < wports; i++)
        if (wena[i]) lvt[waddr[i]] <= sw'(i);
    end
  end

  logic [rports-1:0][width-1:0] rnext;

  always_comb begin
    for (int r = 0; r < rports; r++) begin
      rnext[r] = '0;
      for (int i = 0; i < wports; i++)
        if (lvt[raddr[r]] == sw'(i)) rnext[r] = brd[i][r];
`ifdef LVTRAM_BYPASS_EN
      for (int i = 0; i < wports; i++)
        if (wena[i] && waddr[i] == raddr[r]) rnext[r] = wvalue[i];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalue <= '0;
    end else if (!run) begin
      rvalue <= '0;
    end else begin
      for (int r = 0; r < rports; r++)
        if (rena[r]) rvalue[r] <= rnext[r];
    end
  end

endmodule

// File: tb/tb_lvtram.sv
// Directed bench for lvtram (width 16, depth 8, 2 read ports, 3 write ports).
module tb_lvtram;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 clear;
  logic                 ready;
  logic [1:0]           rena;
  logic [1:0][2:0]      raddr;
  logic [1:0][15:0]     rvalue;
  logic [2:0]           wena;
  logic [2:0][2:0]      waddr;
  logic [2:0][15:0]     wvalue;

  int errors = 0;
  int checks = 0;

  lvtram #(.width(16), .depth(8), .rports(2), .wports(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .ready  (ready),
    .rena   (rena),
    .raddr  (raddr),
    .rvalue (rvalue),
    .wena   (wena),
    .waddr  (waddr),
    .wvalue (wvalue)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    clear = 1'b0; rena = '0; wena = '0;
  endtask

  task automatic ready_after_release(input string tag);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk(tag, {15'd0, ready}, (k == 8) ? 16'd1 : 16'd0);
    end
  endtask

  logic [15:0] byp_exp;

  initial begin
`ifdef LVTRAM_BYPASS_EN
    byp_exp = 16'h0002;
`else
    byp_exp = 16'h0001;
`endif
    rst = 1'b1; idle(); raddr = '0; waddr = '0; wvalue = '0;
    tick();
    chk("rst_ready", {15'd0, ready}, 16'd0);
    chk("rst_rv0", rvalue[0], 16'h0000);
    chk("rst_rv1", rvalue[1], 16'h0000);

    rst = 1'b0;
    ready_after_release("init_ready");

    for (int a = 0; a < 8; a++) begin
      rena = 2'b11; raddr[0] = 3'(a); raddr[1] = 3'(7 - a);
      tick();
      chk("init_rd0", rvalue[0], 16'h0000);
      chk("init_rd1", rvalue[1], 16'h0000);
    end

    // single write then read
    idle(); wena = 3'b010; waddr[1] = 3'd3; wvalue[1] = 16'h1234;
    tick();
    idle(); rena = 2'b01; raddr[0] = 3'd3;
    tick();
    chk("wr_rd", rvalue[0], 16'h1234);

    // three-way collision
    idle(); wena = 3'b111; waddr = {3'd5, 3'd5, 3'd5};
    wvalue[0] = 16'hAAAA; wvalue[1] = 16'hBBBB; wvalue[2] = 16'hCCCC;
    tick();
    idle(); rena = 2'b11; raddr[0] = 3'd5; raddr[1] = 3'd5;
    tick();
    chk("coll_rd0", rvalue[0], 16'hCCCC);
    chk("coll_rd1", rvalue[1], 16'hCCCC);

    // same-cycle read of an address being written
    idle(); wena = 3'b001; waddr[0] = 3'd2; wvalue[0] = 16'h0001;
    tick();
    idle(); wena = 3'b100; waddr[2] = 3'd2; wvalue[2] = 16'h0002;
    rena = 2'b01; raddr[0] = 3'd2;
    tick();
    chk("bypass", rvalue[0], byp_exp);
    idle(); rena = 2'b01; raddr[0] = 3'd2;
    tick();
    chk("after_wr", rvalue[0], 16'h0002);

    // read-enable hold
    idle(); rena = 2'b10; raddr[1] = 3'd3;
    tick();
    chk("hold_pre", rvalue[1], 16'h1234);
    for (int k = 0; k < 3; k++) begin
      idle(); rena = 2'b01; raddr[0] = 3'd5; raddr[1] = 3'(k * 2 + 1 + 4);
      tick();
      chk("hold_rv1", rvalue[1], 16'h1234);
      chk("hold_rv0", rvalue[0], 16'hCCCC);
    end

    // clear: ready low 8 cycles, user writes and reads ignored
    idle(); clear = 1'b1;
    tick();
    chk("clr_ready0", {15'd0, ready}, 16'd0);
    for (int k = 1; k <= 8; k++) begin
      idle(); wena = 3'b111; rena = 2'b11;
      waddr = {3'(k), 3'(7 - k), 3'(k + 2)};
      wvalue = {16'h5555, 16'h6666, 16'h7777};
      raddr[0] = 3'd3; raddr[1] = 3'd5;
      tick();
      chk("clr_ready", {15'd0, ready}, (k == 8) ? 16'd1 : 16'd0);
      if (k >= 2 && k <= 7) chk("clr_rv0", rvalue[0], 16'h0000);
    end
    for (int a = 0; a < 8; a++) begin
      idle(); rena = 2'b11; raddr[0] = 3'(a); raddr[1] = 3'(a);
      tick();
      chk("clr_rd0", rvalue[0], 16'h0000);
      chk("clr_rd1", rvalue[1], 16'h0000);
    end

    // async reset during operation
    idle(); wena = 3'b100; waddr[2] = 3'd1; wvalue[2] = 16'h7777;
    tick();
    idle(); rena = 2'b01; raddr[0] = 3'd1;
    tick();
    chk("pre_rst_rd", rvalue[0], 16'h7777);
    idle();
    #2 rst = 1'b1;
    #1;
    chk("op_rst_ready", {15'd0, ready}, 16'd0);
    chk("op_rst_rv0", rvalue[0], 16'h0000);
    tick();
    rst = 1'b0;
    ready_after_release("op_rel_ready");

    // async reset mid-sweep
    idle(); rena = 2'b01; raddr[0] = 3'd1;
    tick();
    chk("sweep_pre_rd", rvalue[0], 16'h0000);
    idle(); clear = 1'b1;
    tick();
    idle();
    for (int k = 0; k < 4; k++) tick();
    #2 rst = 1'b1;
    #1;
    chk("sweep_rst_ready", {15'd0, ready}, 16'd0);
    chk("sweep_rst_rv1", rvalue[1], 16'h0000);
    tick();
    rst = 1'b0;
    ready_after_release("sweep_rel_ready");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lvtram.md
# lvtram

Parametrised multi-write-port, multi-read-port RAM built on a live-value table (LVT) over per-write-port banks, with registered reads, per-port read enables, deterministic write-collision priority and a hardware initialisation sweep. It replaces the combinational-read multi-write RAM in register files, rename tables and other multi-issue structures that need a known post-reset content and a timing-clean read path.

## Interface
- width, 64, data bits per entry
- depth, 64, entries; power of two, ≥ 2
- rports, 2, read ports
- wports, 2, write ports; ≥ 1
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- clear  in  1  restart the initialisation sweep
- ready  out  1  high when the array accepts reads/writes
- rena  in  [rports]  per-port read enable
- raddr  in  [rports][$clog2(depth)]  read addresses
- rvalue  out  [rports][width]  registered read data
- wena  in  [wports]  per-port write enable
- waddr  in  [wports][$clog2(depth)]  write addresses
- wvalue  in  [wports][width]  write data

## Operation
- One clock (clk); reset asynchronous, active-high (rst).
- States: INIT, RUN.
  - rst → INIT, sweep counter 0, ready 0, all rvalue 0.
  - INIT: each cycle writes 0 to entry cnt of bank 0 and sets LVT[cnt] = 0; cnt increments; at cnt = depth-1 the next state is RUN.
  - RUN: clear = 1 → INIT with cnt = 0 next cycle.
  - clear in INIT restarts cnt at 0.
- In INIT, user writes are dropped, rena is ignored and rvalue is held at 0.
- RUN writes:
  - Port i with wena[i] writes wvalue[i] into bank i at waddr[i] and sets LVT[waddr[i]] = i.
  - Collision: when several ports write the same address in one cycle, the highest port index wins in the LVT, so the lower ports' bank writes are invisible.
- RUN reads:
  - Port r with rena[r] samples bank[LVT[raddr[r]]][raddr[r]] into rvalue[r].
  - rena[r] = 0 → rvalue[r] holds its value.
- LVT select width: selwd = 1 when wports == 1, else $clog2(wports).

## Timing
- Read latency is 1 cycle: raddr/rena at edge N → rvalue valid after edge N.
- Write visible to reads issued on the cycle after the write edge.
- Same-cycle read of an address being written: see Configuration.
- ready is a registered output equal to (state == RUN).
- After rst deassertion, ready rises on the depth-th clock edge.
- After clear is sampled in RUN, ready is 0 from the next edge for exactly depth cycles.
- Reset mid-sweep or mid-operation returns immediately to the reset values; previous contents are not guaranteed afterwards.

## Configuration
- LVTRAM_BYPASS_EN defined:
  - A read in RUN whose raddr equals an enabled waddr in the same cycle returns the winning (highest-index) wvalue on the next edge.
  - The forwarding path is combinational from wvalue to the rvalue register input.
- LVTRAM_BYPASS_EN undefined:
  - The same case returns the pre-write content.
  - There is no wvalue→rvalue path.

## Structure
- Package lvtram_pkg holds:
  - the state typedef (INIT, RUN)
  - the selwd computation as a function of wports
- Sub-module lvtram_bank: one write port, rports combinational read ports, depth × width, no reset on the storage.
  - Instantiated wports times.
  - The INIT zero-write is muxed into bank 0's write port.
- The LVT is flops with async reset; the sweep counter and state register live in the top.

## Test plan
All scenarios use width=16, depth=8, rports=2, wports=3.
- Reset/init: assert rst, release → ready = 0 for 8 edges then 1; read every address → all 0x0000.
- Write/read: port1 writes 0x1234 @3; next cycle read @3 on port0 → rvalue[0] = 0x1234 one edge later.
- Collision: ports 0, 1 and 2 write 0xAAAA, 0xBBBB, 0xCCCC @5 in one cycle → subsequent read @5 = 0xCCCC on both read ports.
- Bypass: memory @2 = 0x0001; write 0x0002 @2 while reading @2 in the same cycle → 0x0002 with LVTRAM_BYPASS_EN, 0x0001 without.
- Hold/clear:
  - rena[1] = 0 for 3 cycles while raddr changes → rvalue[1] unchanged.
  - Pulse clear → ready low 8 cycles, user writes dropped, then all reads = 0.
- Async reset mid-sweep: assert rst at cycle 4 of INIT, off-edge → ready and rvalue 0 immediately; the sweep restarts at 0 and ready rises 8 edges after release.
